// File: rtl/game_score_display.sv
// Display stage for the game: converts the binary score to BCD with a
// sequential double-dabble engine, blinks the lives digit after a life is
// lost, and scans four seven-segment digits with registered outputs.
module game_score_display #(
  parameter int clk_mhz       = 50,
  parameter int w_digit       = 8,
  parameter int w_score       = 8,
  parameter int scan_div      = clk_mhz * 1000,
  parameter int blink_half    = clk_mhz * 250000,
  parameter int blink_toggles = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [w_score-1:0] score,
  input  logic [2:0]         n_lifes,
  input  logic               game_over,
  output logic [7:0]         abcdefgh,
  output logic [w_digit-1:0] digit,
  output logic               conv_busy
);

  localparam int scan_w = $clog2(scan_div + 1);
  localparam int tmr_w  = $clog2(blink_half + 1);
  localparam int bc_w   = $clog2(blink_toggles + 1);
  localparam int cnt_w  = $clog2(w_score + 1);

  localparam logic [7:0] seg_dash = 8'b00000010;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;

  // Seven-segment pattern for a decimal digit, a = bit 7, dot = bit 0.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b11111100;
      4'd1:    s = 8'b01100000;
      4'd2:    s = 8'b11011010;
      4'd3:    s = 8'b11110010;
      4'd4:    s = 8'b01100110;
      4'd5:    s = 8'b10110110;
      4'd6:    s = 8'b10111110;
      4'd7:    s = 8'b11100000;
      4'd8:    s = 8'b11111110;
      4'd9:    s = 8'b11110110;
      default: s = 8'b00000000;
    endcase
    return s;
  endfunction

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  function automatic logic [11:0] dabble_adj(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  conv_state_e        state_q;
  logic [w_score-1:0] score_q;
  logic [w_score-1:0] bin_q;
  logic [11:0]        bcd_q;
  logic [cnt_w-1:0]   bit_cnt_q;
  logic               busy_q;
  logic [3:0]         units_q, tens_q, hund_q;

  logic [2:0]         lifes_q;
  logic [bc_w-1:0]    blink_cnt_q;
  logic [tmr_w-1:0]   blink_tmr_q;

  logic [scan_w-1:0]  pre_q;
  logic [1:0]         idx_q;
  logic [7:0]         seg_q, seg_d;
  logic [w_digit-1:0] digit_q, digit_d;
  logic               lives_blank;

  // BCD conversion FSM; the display registers load only in DONE so they are
  // never seen half-converted.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      score_q   <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      units_q   <= '0;
      tens_q    <= '0;
      hund_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (score != score_q) begin
            score_q   <= score;
            bin_q     <= score;
            bcd_q     <= '0;
            bit_cnt_q <= cnt_w'(w_score);
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q     <= {dabble_adj(bcd_q)[10:0], bin_q[w_score-1]};
          bin_q     <= bin_q << 1;
          bit_cnt_q <= bit_cnt_q - 1'b1;
          if (bit_cnt_q == cnt_w'(1)) state_q <= DONE;
        end
        default: begin
          units_q <= bcd_q[3:0];
          tens_q  <= bcd_q[7:4];
          hund_q  <= bcd_q[11:8];
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Lives tracking: a drop in the life count (re)starts a blink burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lifes_q     <= '0;
      blink_cnt_q <= '0;
      blink_tmr_q <= '0;
    end else begin
      lifes_q <= n_lifes;
      if (n_lifes < lifes_q) begin
        blink_cnt_q <= bc_w'(blink_toggles);
        blink_tmr_q <= tmr_w'(blink_half);
      end else if (blink_cnt_q != '0) begin
        if (blink_tmr_q == tmr_w'(1)) begin
          blink_cnt_q <= blink_cnt_q - 1'b1;
          blink_tmr_q <= tmr_w'(blink_half);
        end else begin
          blink_tmr_q <= blink_tmr_q - 1'b1;
        end
      end
    end
  end

  // Counting down from an even load, the even counts are the blank halves.
  assign lives_blank = (blink_cnt_q != '0) && !blink_cnt_q[0];

  // Scan prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == scan_w'(scan_div - 1)) begin
      pre_q <= '0;
      idx_q <= idx_q + 1'b1;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Next segment/digit pattern for the currently selected digit.
  // NOTE: outputs get a default before the case so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    seg_d   = 8'h00;
    digit_d = w_digit'(1) << idx_q;
    case (idx_q)
      2'd0: seg_d = seg7(units_q);
      2'd1: if (hund_q != 4'd0 || tens_q != 4'd0) seg_d = seg7(tens_q);
      2'd2: if (hund_q != 4'd0) seg_d = seg7(hund_q);
      default: begin
        if (game_over)         seg_d = seg_dash;
        else if (!lives_blank) seg_d = seg7({1'b0, lifes_q});
      end
    endcase
  end

  // Registered display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q   <= '0;
      digit_q <= '0;
    end else begin
      seg_q   <= seg_d;
      digit_q <= digit_d;
    end
  end

  assign abcdefgh  = seg_q;
  assign digit     = digit_q;
  assign conv_busy = busy_q;

endmodule

// File: tb/tb_game_score_display.sv
// Directed bench for game_score_display. A main instance (scan_div=4) covers
// scanning and conversion; a second instance (scan_div=1) shows the lives
// digit every fourth cycle so each blink half-period is visible.
module tb_game_score_display;

  localparam logic [7:0] SEG0 = 8'b11111100;
  localparam logic [7:0] SEG1 = 8'b01100000;
  localparam logic [7:0] SEG2 = 8'b11011010;
  localparam logic [7:0] SEG3 = 8'b11110010;
  localparam logic [7:0] SEG5 = 8'b10110110;
  localparam logic [7:0] SEG7 = 8'b11100000;
  localparam logic [7:0] SEG9 = 8'b11110110;
  localparam logic [7:0] BLNK = 8'b00000000;
  localparam logic [7:0] DASH = 8'b00000010;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] score = '0;
  logic [2:0] n_lifes = 3'd3;
  logic       game_over = 1'b0;
  logic [7:0] seg;
  logic [7:0] dig;
  logic       busy;

  logic [7:0] score_b = '0;
  logic [2:0] n_lifes_b = 3'd3;
  logic       game_over_b = 1'b0;
  logic [7:0] seg_b;
  logic [7:0] dig_b;
  logic       busy_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  game_score_display #(
    .clk_mhz(50), .w_digit(8), .w_score(8),
    .scan_div(4), .blink_half(8), .blink_toggles(6)
  ) dut (
    .clk(clk), .rst(rst), .score(score), .n_lifes(n_lifes),
    .game_over(game_over), .abcdefgh(seg), .digit(dig), .conv_busy(busy)
  );

  game_score_display #(
    .clk_mhz(50), .w_digit(8), .w_score(8),
    .scan_div(1), .blink_half(8), .blink_toggles(6)
  ) dut_b (
    .clk(clk), .rst(rst), .score(score_b), .n_lifes(n_lifes_b),
    .game_over(game_over_b), .abcdefgh(seg_b), .digit(dig_b), .conv_busy(busy_b)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Samples the main instance for more than one scan frame and returns the
  // pattern seen on each digit (X if a digit never lit).
  task automatic read_display(output logic [7:0] u, output logic [7:0] t,
                              output logic [7:0] h, output logic [7:0] l);
    u = 'x; t = 'x; h = 'x; l = 'x;
    for (int i = 0; i < 20; i++) begin
      step();
      case (dig)
        8'h01: u = seg;
        8'h02: t = seg;
        8'h04: h = seg;
        8'h08: l = seg;
        default: ;
      endcase
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_dig;
    logic [7:0] exp_seg;
    score = 8'd0; n_lifes = 3'd3; score_b = 8'd0; n_lifes_b = 3'd3;
    #1 rst = 1'b1;
    step();
    step();
    checks++;
    if (seg !== 8'h00 || dig !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got seg=%b dig=%b busy=%b, want all zero", seg, dig, busy);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      exp_dig = 8'h01 << (i / 4);
      case (i / 4)
        0: exp_seg = SEG0;
        3: exp_seg = SEG3;
        default: exp_seg = BLNK;
      endcase
      checks++;
      if (dig !== exp_dig) begin
        errors++;
        $display("FAIL scan_digit[%0d]: got %b, want %b", i, dig, exp_dig);
      end
      checks++;
      if (seg !== exp_seg) begin
        errors++;
        $display("FAIL scan_seg[%0d]: got %b, want %b", i, seg, exp_seg);
      end
    end
  endtask

  task automatic test_convert_157();
    int busy_cnt;
    logic [7:0] u, t, h, l;
    busy_cnt = 0;
    score = 8'd157;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_rise: got %b, want 1", busy);
        end
      end
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != 9) begin
      errors++;
      $display("FAIL busy_len_157: got %0d cycles, want 9", busy_cnt);
    end
    read_display(u, t, h, l);
    checks++;
    if (h !== SEG1 || t !== SEG5 || u !== SEG7 || l !== SEG3) begin
      errors++;
      $display("FAIL disp_157: got h=%b t=%b u=%b l=%b, want %b %b %b %b",
               h, t, u, l, SEG1, SEG5, SEG7, SEG3);
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] seen;
    logic [29:0] want;
    logic [7:0] u, t, h, l;
    seen = '0;
    want = '0;
    for (int i = 0; i < 30; i++) want[i] = (i <= 8) || (i >= 10 && i <= 18);
    score = 8'd42;
    for (int i = 0; i < 30; i++) begin
      step();
      seen[i] = busy;
      if (i == 2) score = 8'd200;
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("FAIL busy_profile_42_200: got %b, want %b", seen, want);
    end
    read_display(u, t, h, l);
    checks++;
    if (h !== SEG2 || t !== SEG0 || u !== SEG0) begin
      errors++;
      $display("FAIL disp_200: got h=%b t=%b u=%b, want %b %b %b", h, t, u, SEG2, SEG0, SEG0);
    end
  endtask

  task automatic test_suppress();
    logic [7:0] u, t, h, l;
    score = 8'd7;
    for (int i = 0; i < 12; i++) step();
    read_display(u, t, h, l);
    checks++;
    if (h !== BLNK || t !== BLNK || u !== SEG7) begin
      errors++;
      $display("FAIL disp_7: got h=%b t=%b u=%b, want %b %b %b", h, t, u, BLNK, BLNK, SEG7);
    end
    score = 8'd205;
    for (int i = 0; i < 12; i++) step();
    read_display(u, t, h, l);
    checks++;
    if (h !== SEG2 || t !== SEG0 || u !== SEG5) begin
      errors++;
      $display("FAIL disp_205: got h=%b t=%b u=%b, want %b %b %b", h, t, u, SEG2, SEG0, SEG5);
    end
    score = 8'd50;
    for (int i = 0; i < 12; i++) step();
    read_display(u, t, h, l);
    checks++;
    if (h !== BLNK || t !== SEG5 || u !== SEG0) begin
      errors++;
      $display("FAIL disp_50: got h=%b t=%b u=%b, want %b %b %b", h, t, u, BLNK, SEG5, SEG0);
    end
  endtask

  // Output after the n-th edge following a decrement belongs to half-period
  // (n-2)/8; halves 0, 2, 4 are blank, everything from half 6 on is steady.
  task automatic test_blink();
    logic [7:0] exp_seg;
    int h;
    n_lifes_b = 3'd2;
    for (int n = 1; n <= 20; n++) begin
      step();
      h = (n - 2) / 8;
      exp_seg = (h < 6 && (h % 2) == 0) ? BLNK : SEG2;
      if (n >= 2 && dig_b === 8'h08) begin
        checks++;
        if (seg_b !== exp_seg) begin
          errors++;
          $display("FAIL blink_3to2[n=%0d]: got %b, want %b", n, seg_b, exp_seg);
        end
      end
    end
    n_lifes_b = 3'd1;
    for (int m = 1; m <= 60; m++) begin
      step();
      h = (m - 2) / 8;
      exp_seg = (h < 6 && (h % 2) == 0) ? BLNK : SEG1;
      if (m >= 2 && dig_b === 8'h08) begin
        checks++;
        if (seg_b !== exp_seg) begin
          errors++;
          $display("FAIL blink_restart[m=%0d]: got %b, want %b", m, seg_b, exp_seg);
        end
      end
    end
  endtask

  task automatic test_game_over();
    n_lifes_b = 3'd0;
    game_over_b = 1'b1;
    for (int m = 1; m <= 40; m++) begin
      step();
      if (m >= 2 && dig_b === 8'h08) begin
        checks++;
        if (seg_b !== DASH) begin
          errors++;
          $display("FAIL game_over_lives[m=%0d]: got %b, want %b", m, seg_b, DASH);
        end
      end
      if (m >= 2 && dig_b === 8'h01) begin
        checks++;
        if (seg_b !== SEG0) begin
          errors++;
          $display("FAIL game_over_units[m=%0d]: got %b, want %b", m, seg_b, SEG0);
        end
      end
    end
    game_over_b = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] u, t, h, l;
    score = 8'd99;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (seg !== 8'h00 || dig !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_shift: got seg=%b dig=%b busy=%b, want all zero", seg, dig, busy);
    end
    checks++;
    if (seg_b !== 8'h00 || dig_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_blink: got seg=%b dig=%b, want zero", seg_b, dig_b);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_after_reset: got busy=%b, want 1", busy);
    end
    for (int i = 0; i < 10; i++) step();
    read_display(u, t, h, l);
    checks++;
    if (h !== BLNK || t !== SEG9 || u !== SEG9 || l !== SEG3) begin
      errors++;
      $display("FAIL disp_99: got h=%b t=%b u=%b l=%b, want %b %b %b %b",
               h, t, u, l, BLNK, SEG9, SEG9, SEG3);
    end
  endtask

  initial begin
    test_reset();
    test_convert_157();
    test_back_to_back();
    test_suppress();
    test_blink();
    test_game_over();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
